// File: rtl/st_channel_adapter_pipe.sv
// Avalon-ST channel adapter: rebases and narrows the channel, discards out-of-range
// packets whole, counts drops, and registers all outputs behind a two-entry skid buffer.
module st_channel_adapter_pipe #(
  parameter int DATA_W      = 8,
  parameter int IN_CHAN_W   = 8,
  parameter int OUT_CHAN_W  = 2,
  parameter int MAX_CHAN    = 3,
  parameter int CHAN_OFFSET = 0,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  in_ready,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [IN_CHAN_W-1:0]  in_channel,
  input  logic                  in_startofpacket,
  input  logic                  in_endofpacket,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic [OUT_CHAN_W-1:0] out_channel,
  output logic                  out_startofpacket,
  output logic                  out_endofpacket,
  input  logic                  drop_clear,
  output logic [CNT_W-1:0]      drop_count
);

  localparam int BW = DATA_W + OUT_CHAN_W + 2;
  localparam logic [IN_CHAN_W-1:0] OFFSET_C = IN_CHAN_W'(CHAN_OFFSET);
  localparam logic [IN_CHAN_W-1:0] MAX_C    = IN_CHAN_W'(MAX_CHAN);

  typedef enum logic [1:0] {S_IDLE, S_FWD, S_DROP} state_t;

  state_t           state_q, state_d;
  logic             in_ready_q;
  logic             main_valid_q, main_valid_d;
  logic [BW-1:0]    main_q, main_d;
  logic             skid_valid_q, skid_valid_d;
  logic [BW-1:0]    skid_q, skid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [IN_CHAN_W:0]   diff;
  logic [IN_CHAN_W-1:0] rel;
  logic                 in_range;
  logic                 accept;
  logic                 fwd;
  logic                 drop_inc;
  logic                 main_free;
  logic [BW-1:0]        in_beat;

  // The extra MSB of the subtraction is the borrow, flagging channels below the offset.
  assign diff     = {1'b0, in_channel} - {1'b0, OFFSET_C};
  assign rel      = diff[IN_CHAN_W-1:0];
  assign in_range = ~diff[IN_CHAN_W] & (rel <= MAX_C);
  assign accept   = in_valid & in_ready_q;
  assign in_beat  = {in_startofpacket, in_endofpacket, rel[OUT_CHAN_W-1:0], in_data};

  always_comb begin
    state_d  = state_q;
    fwd      = 1'b0;
    drop_inc = 1'b0;
    if (accept) begin
      case (state_q)
        S_IDLE: begin
          fwd = in_range;
          if (in_startofpacket) begin
            if (in_range) begin
              if (!in_endofpacket) state_d = S_FWD;
            end else begin
              drop_inc = 1'b1;
              if (!in_endofpacket) state_d = S_DROP;
            end
          end
        end
        S_FWD: begin
          fwd = 1'b1;
          if (in_endofpacket) state_d = S_IDLE;
        end
        S_DROP: begin
          if (in_endofpacket) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // A beat is only accepted while the skid is empty, so the skid never refills while unloading.
  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    main_free    = ~main_valid_q | out_ready;
    if (main_free) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = fwd;
        if (fwd) main_d = in_beat;
      end
    end else if (fwd) begin
      skid_d       = in_beat;
      skid_valid_d = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (drop_clear) begin
      cnt_d = drop_inc ? CNT_W'(1) : '0;
    end else if (drop_inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      in_ready_q   <= 1'b0;
      main_valid_q <= 1'b0;
      main_q       <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= ~skid_valid_d;
      main_valid_q <= main_valid_d;
      main_q       <= main_d;
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = main_valid_q;
  assign {out_startofpacket, out_endofpacket, out_channel, out_data} = main_q;
  assign drop_count = cnt_q;

endmodule
